// File: rtl/red_pkg.sv
// Shared types and helpers for the RED lane-sum reduction unit (red_seq).
package red_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } red_state_e;

    localparam logic RED_UNSIGNED = 1'b0;
    localparam logic RED_SIGNED   = 1'b1;

    // Accumulator width: one lane, one bit for the pair sum, plus growth over all lanes.
    function automatic int acc_width(input int lane_w, input int nlanes);
        return lane_w + 1 + $clog2(nlanes);
    endfunction

endpackage

// File: rtl/red_lane_ext.sv
// Combinational lane selector: picks lane i_idx of an operand and extends it to ACC_W.
module red_lane_ext
    import red_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    parameter int ACC_W  = 7,
    parameter int IDX_W  = 2
) (
    input  logic [DATA_W-1:0] i_op,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_mode,
    output logic [ACC_W-1:0]  o_ext
);

    logic [LANE_W-1:0] w_lane;
    logic              w_fill;

    assign w_lane = i_op[int'(i_idx)*LANE_W +: LANE_W];
    assign w_fill = (i_mode == RED_SIGNED) & w_lane[LANE_W-1];
    assign o_ext  = {{(ACC_W-LANE_W){w_fill}}, w_lane};

endmodule

// File: rtl/red_seq.sv
// Multi-cycle lane-sum reduction: one lane pair accumulated per cycle, start/done handshake.
// Optional zf/nf result flags are built when RED_SEQ_FLAGS_EN is defined.
module red_seq
    import red_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    output logic              o_busy,
    output logic              o_done,
`ifdef RED_SEQ_FLAGS_EN
    output logic              o_zf,
    output logic              o_nf,
`endif
    output logic [DATA_W-1:0] o_des_data
);

    localparam int NLANES = DATA_W / LANE_W;
    localparam int ACC_W  = acc_width(LANE_W, NLANES);
    localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    if (DATA_W % LANE_W != 0) begin : g_bad_div
        $error("red_seq: DATA_W must be a multiple of LANE_W");
    end
    if (NLANES < 2) begin : g_bad_lanes
        $error("red_seq: need at least two lanes");
    end
    if (ACC_W > DATA_W) begin : g_bad_acc
        $error("red_seq: accumulator wider than DATA_W");
    end

    red_state_e        r_state;
    logic [DATA_W-1:0] r_src1, r_src2, r_des;
    logic              r_mode, r_busy, r_done;
    logic [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]  r_idx;

    logic [ACC_W-1:0]  w_ext1, w_ext2, w_acc_next;
    logic [DATA_W-1:0] w_des_next;
    logic              w_last;

    red_lane_ext #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_ext1 (
        .i_op(r_src1), .i_idx(r_idx), .i_mode(r_mode), .o_ext(w_ext1)
    );
    red_lane_ext #(.DATA_W(DATA_W), .LANE_W(LANE_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) u_ext2 (
        .i_op(r_src2), .i_idx(r_idx), .i_mode(r_mode), .o_ext(w_ext2)
    );

    assign w_acc_next = r_acc + w_ext1 + w_ext2;
    assign w_des_next = (r_mode == RED_SIGNED) ? DATA_W'($signed(w_acc_next)) : DATA_W'(w_acc_next);
    assign w_last     = (r_idx == IDX_W'(NLANES-1));

`ifdef RED_SEQ_FLAGS_EN
    logic r_zf, r_nf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_src1  <= '0;
            r_src2  <= '0;
            r_mode  <= RED_UNSIGNED;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_des   <= '0;
`ifdef RED_SEQ_FLAGS_EN
            r_zf    <= 1'b1;
            r_nf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new start directly so back-to-back ops skip IDLE.
                IDLE, DONE: begin
                    if (i_start) begin
                        r_src1  <= i_src1;
                        r_src2  <= i_src2;
                        r_mode  <= i_mode;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_des   <= w_des_next;
`ifdef RED_SEQ_FLAGS_EN
                        r_zf    <= (w_des_next == '0);
                        r_nf    <= r_mode & w_des_next[DATA_W-1];
`endif
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_des_data = r_des;
`ifdef RED_SEQ_FLAGS_EN
    assign o_zf       = r_zf;
    assign o_nf       = r_nf;
`endif

endmodule

// File: doc/red_seq.md
# red_seq

Parametrised, multi-cycle lane-sum reduction unit for the datapath's RED instruction class. It splits two DATA_W operands into LANE_W-bit lanes and accumulates one lane pair per cycle under a start/done handshake. The result is extended to DATA_W, in unsigned or signed mode. It sits beside the ALU in the execute stage, and the pipeline stalls on `busy`.

## Interface
- DATA_W, 16, operand/result width; must be a multiple of LANE_W.
- LANE_W, 4, lane width; NLANES = DATA_W/LANE_W, must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  1  0 = unsigned lanes, 1 = signed (two's-complement) lanes; captured with start.
- src1  in  DATA_W  operand 1; captured with start.
- src2  in  DATA_W  operand 2; captured with start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; des_data is valid.
- des_data  out  DATA_W  reduction result; held until the next accepted start.
- zf  out  1  result zero; present only with RED_SEQ_FLAGS_EN.
- nf  out  1  result negative (signed mode only); present only with RED_SEQ_FLAGS_EN.

## Operation
- ACC_W = LANE_W + 1 + $clog2(NLANES); elaboration error if ACC_W > DATA_W.
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: on start, the unit latches src1, src2 and mode, clears acc, sets lane index idx = 0, and moves to RUN.
- RUN: each cycle, acc += ext(src1 lane idx) + ext(src2 lane idx), then idx increments.
  - ext() zero-extends each lane to ACC_W in unsigned mode and sign-extends it in signed mode.
  - Lane 0 is bits [LANE_W-1:0].
  - After lane NLANES-1 the FSM moves to DONE.
- DONE: done = 1 for exactly this cycle; des_data = acc extended to DATA_W (zero-extended if unsigned, sign-extended if signed).
  - start in this cycle is accepted and the FSM goes to RUN (back-to-back).
  - Otherwise the FSM goes to IDLE.
- start in RUN is ignored; latched operands are not disturbed.
- Overflow cannot occur: ACC_W covers 2·NLANES·(2^LANE_W − 1) unsigned and 2·NLANES·(−2^(LANE_W−1)) signed.
- des_data is registered and holds its last value through IDLE and RUN. It updates only on entry to DONE.

## Timing
- Reset values: busy = 0, done = 0, des_data = 0, acc = 0, idx = 0; zf = 1 and nf = 0 when present.
- start is accepted at edge t. busy is high during cycles t+1 … t+NLANES. done is high in cycle t+NLANES+1. Latency is NLANES+1 cycles (5 at defaults).
- Back-to-back throughput is one result per NLANES+1 cycles.
- rst asserted in any state returns the unit to IDLE on the next edge with reset values. An in-flight operation is discarded and no done is issued.
- rst and start in the same cycle: rst wins.

## Configuration
- RED_SEQ_FLAGS_EN defined:
  - zf and nf ports exist and are registered alongside des_data.
  - zf = (des_data == 0).
  - nf = mode & des_data[DATA_W-1].
- RED_SEQ_FLAGS_EN undefined: the ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package red_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the ACC_W computation function;
  - the mode encoding constants RED_UNSIGNED = 0 and RED_SIGNED = 1.
- One sub-module, red_lane_ext. It is combinational: it selects lane idx from a latched operand and extends it to ACC_W according to mode. Two instances are used, one per operand.
- The accumulator adder is inline: a single ACC_W-wide three-input add.

## Test plan
- Unsigned max: src1 = src2 = 0xFFFF, mode = 0 → done in cycle t+5, des_data = 0x0078 (120).
- Signed: src1 = src2 = 0xFFFF, mode = 1 → des_data = 0xFFF8 (−8). Then src1 = src2 = 0x8888, mode = 1 → 0xFFC0 (−64), nf = 1 with flags enabled.
- Mixed lanes: src1 = 0x1234, src2 = 0x4321, mode = 0 → 0x0014. Raise start again during busy with 0xFFFF operands → ignored, result is still 0x0014.
- Back-to-back: assert start in the DONE cycle with src1 = 0x0000, src2 = 0x0000 → second done exactly 5 cycles later, des_data = 0x0000, zf = 1.
- Reset mid-operation: assert rst at t+2 → busy = 0 and done = 0 next cycle, des_data = 0, no done pulse follows. A fresh start then completes normally.
- Parameter sweep: DATA_W = 32, LANE_W = 8, src1 = src2 = 0xFFFFFFFF, unsigned → done at t+5, des_data = 0x000007F8 (2040).
